// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin IFU/LSU arbiter with programmable access latency in front of a single memory
// Holds one transaction at a time: IDLE accepts, WAIT counts down to the access cycle, RESP holds the response.
module mem_arbiter #(
    parameter int LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_req_addr,
    output logic        ifu_resp_valid,
    input  logic        ifu_resp_ready,
    output logic [31:0] ifu_resp_data,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_req_addr,
    input  logic        lsu_req_wen,
    input  logic [31:0] lsu_req_wdata,
    input  logic [3:0]  lsu_req_wmask,
    output logic        lsu_resp_valid,
    input  logic        lsu_resp_ready,
    output logic [31:0] lsu_resp_data,
    output logic        mem_ren,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic        mem_wen,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);
    localparam logic       OWN_IFU  = 1'b0;
    localparam logic       OWN_LSU  = 1'b1;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        wen_q, wen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [31:0] rdata_q, rdata_d;

    logic grant_ifu;
    logic grant_lsu;

    // On a tie the port that did not win last time gets the grant.
    assign grant_ifu = ifu_req_valid && (!lsu_req_valid || last_q == OWN_LSU);
    assign grant_lsu = lsu_req_valid && !grant_ifu;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        wen_d          = wen_q;
        wdata_d        = wdata_q;
        wmask_d        = wmask_q;
        owner_d        = owner_q;
        last_d         = last_q;
        rdata_d        = rdata_q;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        ifu_resp_data  = 32'd0;
        lsu_resp_data  = 32'd0;
        mem_ren        = 1'b0;
        mem_wen        = 1'b0;
        mem_raddr      = 32'd0;
        mem_waddr      = 32'd0;
        mem_wdata      = 32'd0;
        mem_wmask      = 4'd0;

        case (state_q)
            IDLE: begin
                ifu_req_ready = grant_ifu && !reset;
                lsu_req_ready = grant_lsu && !reset;
                if (ifu_req_valid && ifu_req_ready) begin
                    addr_d  = ifu_req_addr;
                    wen_d   = 1'b0;
                    wdata_d = 32'd0;
                    wmask_d = 4'd0;
                    owner_d = OWN_IFU;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end else if (lsu_req_valid && lsu_req_ready) begin
                    addr_d  = lsu_req_addr;
                    wen_d   = lsu_req_wen;
                    wdata_d = lsu_req_wdata;
                    wmask_d = lsu_req_wmask;
                    owner_d = OWN_LSU;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    // Gating with reset drops a pending write before it reaches memory.
                    mem_ren = !wen_q && !reset;
                    mem_wen = wen_q && !reset;
                    if (mem_ren) begin
                        mem_raddr = addr_q;
                    end
                    if (mem_wen) begin
                        mem_waddr = addr_q;
                        mem_wdata = wdata_q;
                        mem_wmask = wmask_q;
                    end
                    rdata_d = wen_q ? 32'd0 : mem_rdata;
                    last_d  = owner_q;
                    state_d = RESP;
                end
            end
            RESP: begin
                ifu_resp_valid = (owner_q == OWN_IFU);
                lsu_resp_valid = (owner_q == OWN_LSU);
                ifu_resp_data  = ifu_resp_valid ? rdata_q : 32'd0;
                lsu_resp_data  = lsu_resp_valid ? rdata_q : 32'd0;
                if ((ifu_resp_valid && ifu_resp_ready) || (lsu_resp_valid && lsu_resp_ready)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            addr_q  <= 32'd0;
            wen_q   <= 1'b0;
            wdata_q <= 32'd0;
            wmask_q <= 4'd0;
            owner_q <= OWN_IFU;
            last_q  <= OWN_LSU;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
